// File: rtl/yonga_can_rx_deserializer_if.sv
// yonga_can_rx_deserializer_if
//   Bundle of the CAN RX deserializer's control inputs and received-frame /
//   status outputs.
//   master : used by the deserializer (drives o_*, reads i_*)
//   slave  : used by the consumer / register block (drives i_*, reads o_*)
//   i_enable        receiver enable; low aborts any frame silently
//   i_sample_pulse  one-clk strobe at the bit sample point
//   i_rx            can_rx level (1 = recessive)
//   i_frame_ack     consumer accepts the held frame
//   o_frame_valid   received frame held on outputs until acknowledged
//   o_msg_id        {2'b0, SID[10:0], IDE, EID[17:0]}
//   o_msg_cfg       {27'b0, RTR, DLC[3:0]}
//   o_data1/2       data bytes 0..3 / 4..7, lowest byte in [7:0]
//   o_err_valid     one-clk error pulse
//   o_err_code      last error: 001 stuff, 010 form, 011 crc, 100 overrun
//   o_busy          frame reception in progress
interface yonga_can_rx_deserializer_if;
    logic        i_enable;
    logic        i_sample_pulse;
    logic        i_rx;
    logic        i_frame_ack;
    logic        o_frame_valid;
    logic [31:0] o_msg_id;
    logic [31:0] o_msg_cfg;
    logic [31:0] o_data1;
    logic [31:0] o_data2;
    logic        o_err_valid;
    logic [2:0]  o_err_code;
    logic        o_busy;

    modport master (
        input  i_enable, i_sample_pulse, i_rx, i_frame_ack,
        output o_frame_valid, o_msg_id, o_msg_cfg, o_data1, o_data2,
               o_err_valid, o_err_code, o_busy
    );

    modport slave (
        output i_enable, i_sample_pulse, i_rx, i_frame_ack,
        input  o_frame_valid, o_msg_id, o_msg_cfg, o_data1, o_data2,
               o_err_valid, o_err_code, o_busy
    );
endinterface

// File: rtl/yonga_can_rx_deserializer.sv
// yonga_can_rx_deserializer
//   CAN receive path. Samples can_rx on the sample strobe, waits for bus idle,
//   detects SOF, destuffs, parses standard/extended data and remote frames,
//   checks CRC-15 and frame form, and presents the frame in the TX register
//   layout (MSG_ID / MSG_CFG / DATA1 / DATA2).
//   clk  clock
//   rst  synchronous active-high reset
//   bus  yonga_can_rx_deserializer_if.master (enable, sample strobe, rx level,
//        frame ack in; frame registers, valid, error pulse/code, busy out)
module yonga_can_rx_deserializer #(
    parameter int unsigned BITS          = 32,
    parameter int unsigned BUS_IDLE_BITS = 11
) (
    input logic                         clk,
    input logic                         rst,
    yonga_can_rx_deserializer_if.master bus
);
    localparam int unsigned IDLE_W      = $clog2(BUS_IDLE_BITS + 1);
    localparam logic [14:0] CRC_POLY    = 15'h4599;
    localparam logic [2:0]  ERR_STUFF   = 3'b001;
    localparam logic [2:0]  ERR_FORM    = 3'b010;
    localparam logic [2:0]  ERR_CRC     = 3'b011;
    localparam logic [2:0]  ERR_OVERRUN = 3'b100;

    typedef enum logic [3:0] {
        WAIT_IDLE, IDLE, ID_A, BIT12, IDE, ID_B, RTR_EXT, RSV, DLC, DATA,
        CRC, CRC_DEL, ACK_SLOT, ACK_DEL, EOF
    } state_t;

    state_t            state, state_n;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_n;
    logic [5:0]        bit_cnt, bit_cnt_n;
    logic [2:0]        run_cnt, run_cnt_n;
    logic              run_val, run_val_n;
    logic [14:0]       crc_calc, crc_calc_n;
    logic [14:0]       crc_recv, crc_recv_n;
    logic [10:0]       sid, sid_n;
    logic [17:0]       eid, eid_n;
    logic              ide_flag, ide_flag_n;
    logic              rtr_flag, rtr_flag_n;
    logic [3:0]        dlc_val, dlc_val_n;
    logic [63:0]       data_bits, data_bits_n;

    logic              frame_valid, frame_valid_n;
    logic [BITS-1:0]   msg_id, msg_id_n;
    logic [BITS-1:0]   msg_cfg, msg_cfg_n;
    logic [BITS-1:0]   data1, data1_n;
    logic [BITS-1:0]   data2, data2_n;
    logic              err_valid, err_valid_n;
    logic [2:0]        err_code, err_code_n;
    logic              busy, busy_n;

    logic              is_stuff;
    logic              stuff_err;
    logic              err_hit;
    logic [2:0]        err_sel;
    logic              frame_done;
    logic [3:0]        dlc_full;
    logic [3:0]        data_len;
    logic [6:0]        data_last;
    logic [5:0]        data_idx;

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        logic fb;
        fb = b ^ c[14];
        return {c[13:0], 1'b0} ^ (fb ? CRC_POLY : 15'd0);
    endfunction

    always_comb begin
        data_len  = rtr_flag ? 4'd0 : ((dlc_val > 4'd8) ? 4'd8 : dlc_val);
        data_last = {data_len, 3'b000} - 7'd1;
        // MSB-first within a byte, byte n at [8n+7:8n]
        data_idx  = {bit_cnt[5:3], ~bit_cnt[2:0]};
        dlc_full  = {dlc_val[2:0], bus.i_rx};
    end

    always_comb begin
        state_n       = state;
        idle_cnt_n    = idle_cnt;
        bit_cnt_n     = bit_cnt;
        run_cnt_n     = run_cnt;
        run_val_n     = run_val;
        crc_calc_n    = crc_calc;
        crc_recv_n    = crc_recv;
        sid_n         = sid;
        eid_n         = eid;
        ide_flag_n    = ide_flag;
        rtr_flag_n    = rtr_flag;
        dlc_val_n     = dlc_val;
        data_bits_n   = data_bits;
        frame_valid_n = frame_valid & ~bus.i_frame_ack;
        msg_id_n      = msg_id;
        msg_cfg_n     = msg_cfg;
        data1_n       = data1;
        data2_n       = data2;
        err_valid_n   = 1'b0;
        err_code_n    = err_code;
        busy_n        = busy;
        is_stuff      = 1'b0;
        stuff_err     = 1'b0;
        err_hit       = 1'b0;
        err_sel       = err_code;
        frame_done    = 1'b0;

        if (!bus.i_enable) begin
            state_n    = WAIT_IDLE;
            idle_cnt_n = '0;
            busy_n     = 1'b0;
        end else if (bus.i_sample_pulse) begin
            if (state inside {ID_A, BIT12, IDE, ID_B, RTR_EXT, RSV, DLC, DATA, CRC}) begin
                if (run_cnt == 3'd5) begin
                    is_stuff  = 1'b1;
                    stuff_err = (bus.i_rx == run_val);
                    run_cnt_n = 3'd1;
                    run_val_n = bus.i_rx;
                end else if (bus.i_rx == run_val) begin
                    run_cnt_n = run_cnt + 3'd1;
                end else begin
                    run_cnt_n = 3'd1;
                    run_val_n = bus.i_rx;
                end
            end

            if (stuff_err) begin
                err_hit = 1'b1;
                err_sel = ERR_STUFF;
            end else if (!is_stuff) begin
                if (state inside {ID_A, BIT12, IDE, ID_B, RTR_EXT, RSV, DLC, DATA})
                    crc_calc_n = crc_step(crc_calc, bus.i_rx);

                case (state)
                    WAIT_IDLE: begin
                        if (!bus.i_rx) begin
                            idle_cnt_n = '0;
                        end else if (idle_cnt == IDLE_W'(BUS_IDLE_BITS - 1)) begin
                            idle_cnt_n = '0;
                            state_n    = IDLE;
                        end else begin
                            idle_cnt_n = idle_cnt + IDLE_W'(1);
                        end
                    end
                    IDLE: begin
                        if (!bus.i_rx) begin
                            state_n     = ID_A;
                            busy_n      = 1'b1;
                            bit_cnt_n   = '0;
                            run_cnt_n   = 3'd1;
                            run_val_n   = 1'b0;
                            // a dominant SOF through a zero-seeded CRC leaves it zero
                            crc_calc_n  = '0;
                            sid_n       = '0;
                            eid_n       = '0;
                            data_bits_n = '0;
                        end
                    end
                    ID_A: begin
                        sid_n = {sid[9:0], bus.i_rx};
                        if (bit_cnt == 6'd10) begin
                            bit_cnt_n = '0;
                            state_n   = BIT12;
                        end else begin
                            bit_cnt_n = bit_cnt + 6'd1;
                        end
                    end
                    BIT12: begin
                        // taken as RTR; overwritten at RTR_EXT when this was SRR
                        rtr_flag_n = bus.i_rx;
                        state_n    = IDE;
                    end
                    IDE: begin
                        ide_flag_n = bus.i_rx;
                        bit_cnt_n  = '0;
                        state_n    = bus.i_rx ? ID_B : RSV;
                    end
                    ID_B: begin
                        eid_n = {eid[16:0], bus.i_rx};
                        if (bit_cnt == 6'd17) begin
                            bit_cnt_n = '0;
                            state_n   = RTR_EXT;
                        end else begin
                            bit_cnt_n = bit_cnt + 6'd1;
                        end
                    end
                    RTR_EXT: begin
                        rtr_flag_n = bus.i_rx;
                        bit_cnt_n  = '0;
                        state_n    = RSV;
                    end
                    RSV: begin
                        if (bit_cnt == {5'd0, ide_flag}) begin
                            bit_cnt_n = '0;
                            state_n   = DLC;
                        end else begin
                            bit_cnt_n = bit_cnt + 6'd1;
                        end
                    end
                    DLC: begin
                        dlc_val_n = dlc_full;
                        if (bit_cnt == 6'd3) begin
                            bit_cnt_n = '0;
                            state_n   = (rtr_flag || dlc_full == 4'd0) ? CRC : DATA;
                        end else begin
                            bit_cnt_n = bit_cnt + 6'd1;
                        end
                    end
                    DATA: begin
                        data_bits_n[data_idx] = bus.i_rx;
                        if ({1'b0, bit_cnt} == data_last) begin
                            bit_cnt_n = '0;
                            state_n   = CRC;
                        end else begin
                            bit_cnt_n = bit_cnt + 6'd1;
                        end
                    end
                    CRC: begin
                        crc_recv_n = {crc_recv[13:0], bus.i_rx};
                        if (bit_cnt == 6'd14) begin
                            bit_cnt_n = '0;
                            state_n   = CRC_DEL;
                        end else begin
                            bit_cnt_n = bit_cnt + 6'd1;
                        end
                    end
                    CRC_DEL: begin
                        if (crc_recv != crc_calc) begin
                            err_hit = 1'b1;
                            err_sel = ERR_CRC;
                        end else if (!bus.i_rx) begin
                            err_hit = 1'b1;
                            err_sel = ERR_FORM;
                        end else begin
                            state_n = ACK_SLOT;
                        end
                    end
                    ACK_SLOT: state_n = ACK_DEL;
                    ACK_DEL: begin
                        if (!bus.i_rx) begin
                            err_hit = 1'b1;
                            err_sel = ERR_FORM;
                        end else begin
                            bit_cnt_n = '0;
                            state_n   = EOF;
                        end
                    end
                    EOF: begin
                        if (!bus.i_rx) begin
                            err_hit = 1'b1;
                            err_sel = ERR_FORM;
                        end else if (bit_cnt == 6'd6) begin
                            frame_done = 1'b1;
                        end else begin
                            bit_cnt_n = bit_cnt + 6'd1;
                        end
                    end
                    default: state_n = WAIT_IDLE;
                endcase
            end

            if (err_hit) begin
                err_valid_n = 1'b1;
                err_code_n  = err_sel;
                busy_n      = 1'b0;
                state_n     = WAIT_IDLE;
                idle_cnt_n  = '0;
            end else if (frame_done) begin
                busy_n     = 1'b0;
                state_n    = WAIT_IDLE;
                idle_cnt_n = '0;
                if (frame_valid && !bus.i_frame_ack) begin
                    err_valid_n = 1'b1;
                    err_code_n  = ERR_OVERRUN;
                end else begin
                    frame_valid_n = 1'b1;
                    msg_id_n      = BITS'({2'b00, sid, ide_flag, ide_flag ? eid : 18'd0});
                    msg_cfg_n     = BITS'({rtr_flag, dlc_val});
                    data1_n       = BITS'(data_bits[31:0]);
                    data2_n       = BITS'(data_bits[63:32]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_IDLE;
            idle_cnt    <= '0;
            bit_cnt     <= '0;
            run_cnt     <= '0;
            run_val     <= 1'b0;
            crc_calc    <= '0;
            crc_recv    <= '0;
            sid         <= '0;
            eid         <= '0;
            ide_flag    <= 1'b0;
            rtr_flag    <= 1'b0;
            dlc_val     <= '0;
            data_bits   <= '0;
            frame_valid <= 1'b0;
            msg_id      <= '0;
            msg_cfg     <= '0;
            data1       <= '0;
            data2       <= '0;
            err_valid   <= 1'b0;
            err_code    <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            idle_cnt    <= idle_cnt_n;
            bit_cnt     <= bit_cnt_n;
            run_cnt     <= run_cnt_n;
            run_val     <= run_val_n;
            crc_calc    <= crc_calc_n;
            crc_recv    <= crc_recv_n;
            sid         <= sid_n;
            eid         <= eid_n;
            ide_flag    <= ide_flag_n;
            rtr_flag    <= rtr_flag_n;
            dlc_val     <= dlc_val_n;
            data_bits   <= data_bits_n;
            frame_valid <= frame_valid_n;
            msg_id      <= msg_id_n;
            msg_cfg     <= msg_cfg_n;
            data1       <= data1_n;
            data2       <= data2_n;
            err_valid   <= err_valid_n;
            err_code    <= err_code_n;
            busy        <= busy_n;
        end
    end

    assign bus.o_frame_valid = frame_valid;
    assign bus.o_msg_id      = msg_id;
    assign bus.o_msg_cfg     = msg_cfg;
    assign bus.o_data1       = data1;
    assign bus.o_data2       = data2;
    assign bus.o_err_valid   = err_valid;
    assign bus.o_err_code    = err_code;
    assign bus.o_busy        = busy;
endmodule
